// File: rtl/word16_serializer.sv
// Parallel-to-serial transmitter: one word per load handshake, one bit per serial beat.
// Optional even-parity trailer beat when WORD16_SERIALIZER_PARITY_EN is defined.
module word16_serializer #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_last
);

    localparam int CW = $clog2(WIDTH + 2);

`ifdef WORD16_SERIALIZER_PARITY_EN
    // Counter runs WIDTH..0; the beat at count 0 carries the parity bit.
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
`else
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg_shifted;
    logic             next_bit;

`ifdef WORD16_SERIALIZER_PARITY_EN
    logic             par;
`endif

    always_comb begin
        sreg_shifted = LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
        next_bit     = LSB_FIRST ? sreg[1] : sreg[WIDTH-2];
`ifdef WORD16_SERIALIZER_PARITY_EN
        if (cnt == CW'(1)) begin
            next_bit = par;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            ser_valid  <= 1'b0;
            ser_out    <= 1'b0;
            ser_last   <= 1'b0;
            sreg       <= '0;
            cnt        <= '0;
`ifdef WORD16_SERIALIZER_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        state      <= SHIFT;
                        sreg       <= load_data;
                        cnt        <= CNT_LOAD;
`ifdef WORD16_SERIALIZER_PARITY_EN
                        par        <= ^load_data;
`endif
                        ser_out    <= LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
                        ser_valid  <= 1'b1;
                        ser_last   <= 1'b0;
                        load_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Without ser_ready every output and the register simply hold.
                    if (ser_ready) begin
                        if (cnt == '0) begin
                            state      <= IDLE;
                            ser_valid  <= 1'b0;
                            ser_last   <= 1'b0;
                            ser_out    <= 1'b0;
                            load_ready <= 1'b1;
                        end else begin
                            sreg     <= sreg_shifted;
                            cnt      <= cnt - CW'(1);
                            ser_out  <= next_bit;
                            ser_last <= (cnt == CW'(1));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
